// File: rtl/vwb_pkg.sv
// Shared types for the vector-lane writeback stage.
// Exec-result bundle and load element-width code.
package vwb_pkg;

  localparam int WB_DW = 64;
  localparam int WB_AW = 5;
  localparam logic [2:0] SEW_64 = 3'b011;

  typedef struct packed {
    logic [WB_DW-1:0] data;
    logic [WB_AW-1:0] dest;
    logic [2:0]       sew;
    logic             masked;
    logic [WB_DW-1:0] operand_3;
  } wb_exec_entry_t;

endpackage

// File: rtl/vwb_fifo.sv
// Generic synchronous FIFO with wrap pointers and an entry peek port.
// valid[i] marks slots currently holding queued data.
module vwb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              din,
  output logic [WIDTH-1:0]              dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH):0]        count,
  output logic [DEPTH-1:0][WIDTH-1:0]   entries,
  output logic [DEPTH-1:0]              valid
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]                  wptr;
  logic [AW:0]                  rptr;
  logic [DEPTH-1:0][WIDTH-1:0]  mem;
  logic [AW-1:0]                off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      mem  <= '0;
    end else begin
      if (push && !full) begin
        mem[wptr[AW-1:0]] <= din;
        wptr <= wptr + 1'b1;
      end
      if (pop && !empty)
        rptr <= rptr + 1'b1;
    end
  end

  assign count   = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = ((wptr ^ rptr) == {1'b1, {AW{1'b0}}});
  assign dout    = mem[rptr[AW-1:0]];
  assign entries = mem;

  // A slot is live when its distance from the read pointer is below count
  always_comb begin
    valid = '0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = AW'(i) - rptr[AW-1:0];
      valid[i] = ({1'b0, off} < count);
    end
  end

endmodule

// File: rtl/vlane_writeback_mq.sv
// Vector-lane writeback: load-dest queue, exec FIFO, one registered RF port.
// Optional WB_BYPASS_EN lets an exec result skip an empty FIFO.
module vlane_writeback_mq
  import vwb_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DW,
  parameter int REG_AW     = WB_AW,
  parameter int LQ_DEPTH   = 4,
  parameter int EQ_DEPTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ld_issue_valid,
  input  logic [REG_AW-1:0]      ld_issue_dest,
  output logic                   ld_issue_ready,
  input  logic                   ld_rsp_valid,
  input  logic [DATA_WIDTH-1:0]  ld_rsp_data,
  input  logic                   ex_valid,
  output logic                   ex_ready,
  input  logic [DATA_WIDTH-1:0]  ex_data,
  input  logic [REG_AW-1:0]      ex_dest,
  input  logic [2:0]             ex_sew,
  input  logic                   ex_masked,
  input  logic [DATA_WIDTH-1:0]  ex_operand_3,
  output logic                   rf_we,
  output logic [DATA_WIDTH-1:0]  rf_data,
  output logic [REG_AW-1:0]      rf_dest,
  output logic [2:0]             rf_sew,
  output logic                   rf_masked,
  output logic [DATA_WIDTH-1:0]  rf_operand_3,
  output logic                   rf_is_load,
  output logic [2**REG_AW-1:0]   pending_mask,
  output logic                   ld_orphan
);

  localparam int EW = $bits(wb_exec_entry_t);

  logic                               lq_full;
  logic                               lq_empty;
  logic [$clog2(LQ_DEPTH):0]          lq_count;
  logic [REG_AW-1:0]                  lq_head;
  logic [LQ_DEPTH-1:0][REG_AW-1:0]    lq_entries;
  logic [LQ_DEPTH-1:0]                lq_valid;

  logic                               eq_full;
  logic                               eq_empty;
  logic [$clog2(EQ_DEPTH):0]          eq_count;
  logic [EQ_DEPTH-1:0][EW-1:0]        eq_entries;
  logic [EQ_DEPTH-1:0]                eq_valid;
  wb_exec_entry_t                     eq_head;
  wb_exec_entry_t                     ex_in;

  logic ld_match;
  logic ex_acc;
  logic ex_byp;
  logic eq_push;
  logic sel_eq;
  logic unused_peek;

  assign ld_issue_ready = ~lq_full;
  assign ex_ready       = ~eq_full;
  assign ld_match       = ld_rsp_valid & ~lq_empty;
  assign ex_acc         = ex_valid & ex_ready;
  assign sel_eq         = ~ld_match & ~eq_empty;

`ifdef WB_BYPASS_EN
  assign ex_byp = ex_acc & eq_empty & ~ld_match;
`else
  assign ex_byp = 1'b0;
`endif

  assign eq_push = ex_acc & ~ex_byp;

  assign ex_in = '{
    data:      ex_data,
    dest:      ex_dest,
    sew:       ex_sew,
    masked:    ex_masked,
    operand_3: ex_operand_3
  };

  vwb_fifo #(
    .WIDTH (REG_AW),
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (ld_issue_valid & ld_issue_ready),
    .pop     (ld_match),
    .din     (ld_issue_dest),
    .dout    (lq_head),
    .full    (lq_full),
    .empty   (lq_empty),
    .count   (lq_count),
    .entries (lq_entries),
    .valid   (lq_valid)
  );

  vwb_fifo #(
    .WIDTH (EW),
    .DEPTH (EQ_DEPTH)
  ) u_eq (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (eq_push),
    .pop     (sel_eq),
    .din     (ex_in),
    .dout    (eq_head),
    .full    (eq_full),
    .empty   (eq_empty),
    .count   (eq_count),
    .entries (eq_entries),
    .valid   (eq_valid)
  );

  assign unused_peek = ^{lq_count, eq_count, eq_entries, eq_valid};

  // Duplicate dests naturally keep a bit set until the last one pops
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < LQ_DEPTH; i++)
      if (lq_valid[i])
        pending_mask[lq_entries[i]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we        <= 1'b0;
      rf_is_load   <= 1'b0;
      rf_data      <= '0;
      rf_dest      <= '0;
      rf_sew       <= '0;
      rf_masked    <= 1'b0;
      rf_operand_3 <= '0;
      ld_orphan    <= 1'b0;
    end else begin
      if (ld_rsp_valid && lq_empty)
        ld_orphan <= 1'b1;
      unique case (1'b1)
        ld_match: begin
          rf_we        <= 1'b1;
          rf_is_load   <= 1'b1;
          rf_data      <= ld_rsp_data;
          rf_dest      <= lq_head;
          rf_sew       <= SEW_64;
          rf_masked    <= 1'b0;
          rf_operand_3 <= '0;
        end
        sel_eq: begin
          rf_we        <= 1'b1;
          rf_is_load   <= 1'b0;
          rf_data      <= eq_head.data;
          rf_dest      <= eq_head.dest;
          rf_sew       <= eq_head.sew;
          rf_masked    <= eq_head.masked;
          rf_operand_3 <= eq_head.operand_3;
        end
        ex_byp: begin
          rf_we        <= 1'b1;
          rf_is_load   <= 1'b0;
          rf_data      <= ex_data;
          rf_dest      <= ex_dest;
          rf_sew       <= ex_sew;
          rf_masked    <= ex_masked;
          rf_operand_3 <= ex_operand_3;
        end
        default: begin
          rf_we      <= 1'b0;
          rf_is_load <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vlane_writeback_mq.sv
// Testbench for vlane_writeback_mq: directed steps plus random traffic
// against a queue-based reference model.
module tb_vlane_writeback_mq;

  localparam int LQ = 4;
  localparam int EQ = 2;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_issue_valid;
  logic [4:0]  ld_issue_dest;
  logic        ld_issue_ready;
  logic        ld_rsp_valid;
  logic [63:0] ld_rsp_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [63:0] ex_data;
  logic [4:0]  ex_dest;
  logic [2:0]  ex_sew;
  logic        ex_masked;
  logic [63:0] ex_operand_3;
  logic        rf_we;
  logic [63:0] rf_data;
  logic [4:0]  rf_dest;
  logic [2:0]  rf_sew;
  logic        rf_masked;
  logic [63:0] rf_operand_3;
  logic        rf_is_load;
  logic [31:0] pending_mask;
  logic        ld_orphan;

  always #5 clk = ~clk;

  vlane_writeback_mq #(
    .DATA_WIDTH (64),
    .REG_AW     (5),
    .LQ_DEPTH   (LQ),
    .EQ_DEPTH   (EQ)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ld_issue_valid (ld_issue_valid),
    .ld_issue_dest  (ld_issue_dest),
    .ld_issue_ready (ld_issue_ready),
    .ld_rsp_valid   (ld_rsp_valid),
    .ld_rsp_data    (ld_rsp_data),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_data        (ex_data),
    .ex_dest        (ex_dest),
    .ex_sew         (ex_sew),
    .ex_masked      (ex_masked),
    .ex_operand_3   (ex_operand_3),
    .rf_we          (rf_we),
    .rf_data        (rf_data),
    .rf_dest        (rf_dest),
    .rf_sew         (rf_sew),
    .rf_masked      (rf_masked),
    .rf_operand_3   (rf_operand_3),
    .rf_is_load     (rf_is_load),
    .pending_mask   (pending_mask),
    .ld_orphan      (ld_orphan)
  );

  typedef struct {
    logic [63:0] d;
    logic [4:0]  dest;
    logic [2:0]  sew;
    logic        m;
    logic [63:0] op;
  } ent_t;

  logic [4:0] lq[$];
  ent_t       eq[$];

  logic        e_we, e_ld, e_m, e_orph;
  logic [63:0] e_data, e_op;
  logic [4:0]  e_dest;
  logic [2:0]  e_sew;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    ld_issue_valid = 0;
    ld_issue_dest  = '0;
    ld_rsp_valid   = 0;
    ld_rsp_data    = '0;
    ex_valid       = 0;
    ex_data        = '0;
    ex_dest        = '0;
    ex_sew         = '0;
    ex_masked      = 0;
    ex_operand_3   = '0;
  endtask

  task automatic model_reset();
    lq.delete();
    eq.delete();
    e_we = 0; e_ld = 0; e_m = 0; e_orph = 0;
    e_data = '0; e_op = '0; e_dest = '0; e_sew = '0;
  endtask

  task automatic set_ex(ent_t x);
    e_we = 1; e_ld = 0;
    e_data = x.d; e_dest = x.dest; e_sew = x.sew;
    e_m = x.m; e_op = x.op;
  endtask

  // One clock cycle: check handshake/mask, advance model, check outputs
  task automatic step();
    bit match, acc, byp, iss;
    ent_t x;
    logic [31:0] pm;
    #1;
    pm = '0;
    foreach (lq[i]) pm[lq[i]] = 1'b1;
    chk("ld_issue_ready", ld_issue_ready, lq.size() < LQ);
    chk("ex_ready", ex_ready, eq.size() < EQ);
    chk("pending_mask", pending_mask, pm);
    match = ld_rsp_valid && lq.size() > 0;
    iss   = ld_issue_valid && lq.size() < LQ;
    acc   = ex_valid && eq.size() < EQ;
    byp   = BYP && acc && eq.size() == 0 && !match;
    x = '{d: ex_data, dest: ex_dest, sew: ex_sew,
          m: ex_masked, op: ex_operand_3};
    if (ld_rsp_valid && !match) e_orph = 1;
    if (match) begin
      e_we = 1; e_ld = 1; e_data = ld_rsp_data;
      e_dest = lq.pop_front(); e_sew = 3'b011; e_m = 0; e_op = '0;
    end else if (eq.size() > 0) begin
      set_ex(eq.pop_front());
    end else if (byp) begin
      set_ex(x);
    end else begin
      e_we = 0; e_ld = 0;
    end
    if (iss) lq.push_back(ld_issue_dest);
    if (acc && !byp) eq.push_back(x);
    @(posedge clk);
    #1;
    chk("rf_we", rf_we, e_we);
    chk("rf_is_load", rf_is_load, e_ld);
    chk("rf_data", rf_data, e_data);
    chk("rf_dest", rf_dest, e_dest);
    chk("rf_sew", rf_sew, e_sew);
    chk("rf_masked", rf_masked, e_m);
    chk("rf_operand_3", rf_operand_3, e_op);
    chk("ld_orphan", ld_orphan, e_orph);
  endtask

  task automatic issue(logic [4:0] d);
    idle_in();
    ld_issue_valid = 1; ld_issue_dest = d;
    step();
  endtask

  task automatic rsp(logic [63:0] d);
    idle_in();
    ld_rsp_valid = 1; ld_rsp_data = d;
    step();
  endtask

  task automatic set_exin(logic [4:0] d, logic [63:0] v, logic m);
    ex_valid = 1; ex_dest = d; ex_data = v; ex_masked = m;
    ex_sew = 3'($urandom_range(0, 7));
    ex_operand_3 = {$urandom, $urandom};
  endtask

  task automatic idles(int n);
    idle_in();
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    idle_in();
    model_reset();
    rst_n = 0;
    // Reset held with ex_valid asserted
    set_exin(5'd4, 64'h0BAD_F00D, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_pending_mask", pending_mask, 0);
    chk("rst_ex_ready", ex_ready, 1);
    chk("rst_ld_issue_ready", ld_issue_ready, 1);
    chk("rst_ld_orphan", ld_orphan, 0);
    chk("rst_rf_data", rf_data, 0);
    rst_n = 1;
    step();
    chk("first_write_latency", rf_we, BYP);
    idles(2);

    // Duplicate-dest load queue
    issue(5'd3);
    issue(5'd7);
    issue(5'd3);
    issue(5'd9);
    idle_in();
    #1;
    chk("lq_full_ready", ld_issue_ready, 0);
    chk("lq_mask_379", pending_mask, 32'h0000_0288);
    ld_issue_valid = 1; ld_issue_dest = 5'd20;
    ld_rsp_valid = 1; ld_rsp_data = 64'hA;
    step();
    rsp(64'hB);
    rsp(64'hC);
    rsp(64'hD);
    idles(1);
    chk("mask_cleared", pending_mask, 0);

    // Exec vs. load contention
    issue(5'd10);
    issue(5'd11);
    idle_in();
    ld_rsp_valid = 1; ld_rsp_data = 64'h1111;
    set_exin(5'd1, 64'h0101, 0);
    step();
    idle_in();
    ld_rsp_valid = 1; ld_rsp_data = 64'h2222;
    set_exin(5'd2, 64'h0202, 1);
    step();
    idles(3);

    // Exec FIFO fills under continuous load returns
    for (int i = 0; i < 4; i++) issue(5'(12 + i));
    for (int i = 0; i < 4; i++) begin
      idle_in();
      ld_rsp_valid = 1; ld_rsp_data = 64'(32'hF000 + i);
      set_exin(5'(20 + i), 64'(32'hE000 + i), 0);
      step();
    end
    chk("eq_full_ready", ex_ready, 0);
    idles(4);
    chk("eq_drained", ex_ready, 1);

    // Orphan response
    rsp(64'hDEAD);
    chk("orphan_no_we", rf_we, 0);
    idles(3);
    chk("orphan_sticky", ld_orphan, 1);

    // Held fields after exec write
    idle_in();
    set_exin(5'd5, 64'h1234, 1);
    step();
    idles(3);
    chk("hold_we", rf_we, 0);
    chk("hold_dest", rf_dest, 5'd5);
    chk("hold_data", rf_data, 64'h1234);
    chk("hold_masked", rf_masked, 1);

    // Random traffic, with a mid-run reset
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 300; n++) begin
        idle_in();
        ld_issue_valid = ($urandom_range(0, 1) == 1);
        ld_issue_dest  = 5'($urandom);
        ld_rsp_valid   = ($urandom_range(0, 9) < 4);
        ld_rsp_data    = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 1)
          set_exin(5'($urandom), {$urandom, $urandom}, 1'($urandom));
        step();
      end
      do_reset();
      #1;
      chk("midrst_mask", pending_mask, 0);
      chk("midrst_orphan", ld_orphan, 0);
    end
    idles(2);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
